// File: rtl/exe_mem_stage_if.sv
// EX->MEM handshake and payload bundle for exe_mem_stage.
// master = environment (EX producer + MEM consumer), slave = the stage itself.
interface exe_mem_stage_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
);
  logic             ValidE;
  logic             ReadyE;
  logic             FlushM;
  logic             RegWriteE;
  logic             MemWriteE;
  logic             JumpE;
  logic             JumpRegE;
  logic [1:0]       ResultSrcE;
  logic [WIDTH-1:0] AluResultE;
  logic [WIDTH-1:0] WriteDataE;
  logic [WIDTH-1:0] ImmExtE;
  logic [WIDTH-1:0] PCPlus4E;
  logic [RD_W-1:0]  RdE;

  logic             ValidM;
  logic             ReadyM;
  logic             RegWriteM;
  logic             MemWriteM;
  logic             JumpM;
  logic             JumpRegM;
  logic [1:0]       ResultSrcM;
  logic [WIDTH-1:0] AluResultM;
  logic [WIDTH-1:0] WriteDataM;
  logic [WIDTH-1:0] ImmExtM;
  logic [WIDTH-1:0] PCPlus4M;
  logic [RD_W-1:0]  RdM;

  modport master (
    output ValidE, FlushM, RegWriteE, MemWriteE, JumpE, JumpRegE, ResultSrcE,
           AluResultE, WriteDataE, ImmExtE, PCPlus4E, RdE, ReadyM,
    input  ReadyE, ValidM, RegWriteM, MemWriteM, JumpM, JumpRegM, ResultSrcM,
           AluResultM, WriteDataM, ImmExtM, PCPlus4M, RdM
  );

  modport slave (
    input  ValidE, FlushM, RegWriteE, MemWriteE, JumpE, JumpRegE, ResultSrcE,
           AluResultE, WriteDataE, ImmExtE, PCPlus4E, RdE, ReadyM,
    output ReadyE, ValidM, RegWriteM, MemWriteM, JumpM, JumpRegM, ResultSrcM,
           AluResultM, WriteDataM, ImmExtM, PCPlus4M, RdM
  );
endinterface

// File: rtl/exe_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake and flush.
// Define EXMEM_SKID_EN for the two-entry skid buffer (registered ReadyE).
module exe_mem_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input logic            CLK,
  input logic            RST_N,
  exe_mem_stage_if.slave bus
);

  typedef struct packed {
    logic             RegWrite;
    logic             MemWrite;
    logic             Jump;
    logic             JumpReg;
    logic [1:0]       ResultSrc;
    logic [WIDTH-1:0] AluResult;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ImmExt;
    logic [WIDTH-1:0] PCPlus4;
    logic [RD_W-1:0]  Rd;
  } payload_t;

  payload_t in_pl;
  payload_t main_q;
  logic     valid_m;

  always_comb begin
    in_pl           = '0;
    in_pl.RegWrite  = bus.RegWriteE;
    in_pl.MemWrite  = bus.MemWriteE;
    in_pl.Jump      = bus.JumpE;
    in_pl.JumpReg   = bus.JumpRegE;
    in_pl.ResultSrc = bus.ResultSrcE;
    in_pl.AluResult = bus.AluResultE;
    in_pl.WriteData = bus.WriteDataE;
    in_pl.ImmExt    = bus.ImmExtE;
    in_pl.PCPlus4   = bus.PCPlus4E;
    in_pl.Rd        = bus.RdE;
  end

`ifdef EXMEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

  state_e   state_q;
  payload_t skid_q;

  // ReadyE depends on state only; RST_N gating keeps it low before the first reset edge
  assign bus.ReadyE = RST_N & (state_q != FULL);
  assign valid_m    = (state_q != EMPTY);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (bus.FlushM) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (bus.ValidE) begin
            main_q  <= in_pl;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.ValidE && bus.ReadyM) begin
            main_q <= in_pl;
          end else if (bus.ValidE) begin
            skid_q  <= in_pl;
            state_q <= FULL;
          end else if (bus.ReadyM) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (bus.ReadyM) begin
            main_q  <= skid_q;
            state_q <= BUSY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
`else
  logic valid_q;

  assign bus.ReadyE = RST_N & (bus.ReadyM | ~valid_q);
  assign valid_m    = valid_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (bus.FlushM) begin
      valid_q <= 1'b0;
    end else if (bus.ValidE && bus.ReadyE) begin
      main_q  <= in_pl;
      valid_q <= 1'b1;
    end else if (bus.ReadyM) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign bus.ValidM     = valid_m;
  assign bus.RegWriteM  = main_q.RegWrite & valid_m;
  assign bus.MemWriteM  = main_q.MemWrite & valid_m;
  assign bus.JumpM      = main_q.Jump     & valid_m;
  assign bus.JumpRegM   = main_q.JumpReg  & valid_m;
  assign bus.ResultSrcM = main_q.ResultSrc;
  assign bus.AluResultM = main_q.AluResult;
  assign bus.WriteDataM = main_q.WriteData;
  assign bus.ImmExtM    = main_q.ImmExt;
  assign bus.PCPlus4M   = main_q.PCPlus4;
  assign bus.RdM        = main_q.Rd;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage; covers both the skid and the single-register build.
module tb_exe_mem_stage;
  localparam int WIDTH = 32;
  localparam int RD_W  = 5;

  typedef struct packed {
    logic             rw;
    logic             mw;
    logic             j;
    logic             jr;
    logic [1:0]       rs;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [RD_W-1:0]  rd;
  } pl_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  exe_mem_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();
  exe_mem_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  pl_t q[$];
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  function automatic pl_t rand_pl();
    pl_t p;
    p.rw  = 1'($urandom_range(0, 1));
    p.mw  = 1'($urandom_range(0, 1));
    p.j   = 1'($urandom_range(0, 1));
    p.jr  = 1'($urandom_range(0, 1));
    p.rs  = 2'($urandom_range(0, 3));
    p.alu = $urandom;
    p.wd  = $urandom;
    p.imm = $urandom;
    p.pc  = $urandom;
    p.rd  = RD_W'($urandom_range(0, 31));
    return p;
  endfunction

  task automatic drive(input pl_t p, input logic v);
    bus.ValidE     = v;
    bus.RegWriteE  = p.rw;
    bus.MemWriteE  = p.mw;
    bus.JumpE      = p.j;
    bus.JumpRegE   = p.jr;
    bus.ResultSrcE = p.rs;
    bus.AluResultE = p.alu;
    bus.WriteDataE = p.wd;
    bus.ImmExtE    = p.imm;
    bus.PCPlus4E   = p.pc;
    bus.RdE        = p.rd;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Inputs change at posedge+1, so negedge sees settled values for the coming edge
  always @(negedge CLK) begin
    if (mon_en) begin
      pl_t got, exp, cur;
      logic exp_ready;
`ifdef EXMEM_SKID_EN
      exp_ready = RST_N && (q.size() < 2);
`else
      exp_ready = RST_N && (bus.ReadyM || q.size() == 0);
`endif
      checks++;
      if (bus.ReadyE !== exp_ready) begin
        failures++;
        $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, bus.ReadyE, exp_ready);
      end
      checks++;
      if (bus.ValidM !== (q.size() != 0)) begin
        failures++;
        $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, bus.ValidM, q.size() != 0);
      end
      if (bus.ValidM === 1'b0) begin
        checks++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.JumpM, bus.JumpRegM} !== 4'b0) begin
          failures++;
          $display("FAIL mon_gating t=%0t got=%b exp=0000", $time,
                   {bus.RegWriteM, bus.MemWriteM, bus.JumpM, bus.JumpRegM});
        end
      end
      if (!RST_N || bus.FlushM) begin
        q.delete();
      end else begin
        if (bus.ValidM && bus.ReadyM && q.size() > 0) begin
          exp = q.pop_front();
          got = {bus.RegWriteM, bus.MemWriteM, bus.JumpM, bus.JumpRegM, bus.ResultSrcM,
                 bus.AluResultM, bus.WriteDataM, bus.ImmExtM, bus.PCPlus4M, bus.RdM};
          checks++;
          if (got !== exp) begin
            failures++;
            $display("FAIL mon_payload t=%0t got=%h exp=%h", $time, got, exp);
          end
        end
        if (bus.ValidE && bus.ReadyE) begin
          cur = {bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.JumpRegE, bus.ResultSrcE,
                 bus.AluResultE, bus.WriteDataE, bus.ImmExtE, bus.PCPlus4E, bus.RdE};
          q.push_back(cur);
        end
      end
    end
  end

  task automatic test_reset();
    RST_N = 1'b0;
    bus.FlushM = 1'b0;
    bus.ReadyM = 1'b1;
    drive(rand_pl(), 1'b1);
    cyc();
    cyc();
    checks++;
    if (bus.ValidM !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.ValidM); end
    checks++;
    if (bus.AluResultM !== '0) begin failures++; $display("FAIL rst_alu got=%h exp=0", bus.AluResultM); end
    checks++;
    if (bus.RegWriteM !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", bus.RegWriteM); end
    checks++;
    if (bus.ReadyE !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.ReadyE); end
    drive('0, 1'b0);
    RST_N = 1'b1;
    #1;
    checks++;
    if (bus.ReadyE !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.ReadyE); end
    mon_en = 1'b1;
  endtask

  task automatic test_stream();
    pl_t p;
    logic [WIDTH-1:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    bus.ReadyM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = rand_pl();
      p.alu = vals[i];
      p.rs  = 2'b10;
      p.rw  = 1'b0;
      drive(p, 1'b1);
      cyc();
      checks++;
      if (bus.AluResultM !== vals[i] || bus.ResultSrcM !== 2'b10 || bus.ValidM !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d got alu=%h rs=%b v=%b exp alu=%h rs=10 v=1",
                 i, bus.AluResultM, bus.ResultSrcM, bus.ValidM, vals[i]);
      end
    end
    drive('0, 1'b0);
    cyc();
    checks++;
    if (bus.ValidM !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", bus.ValidM); end
  endtask

  task automatic test_stall();
    pl_t pa, pb;
    pa = rand_pl(); pa.alu = 32'hA;
    pb = rand_pl(); pb.alu = 32'hB;
    bus.ReadyM = 1'b0;
    drive(pa, 1'b1);
    cyc();
    drive(pb, 1'b1);
`ifdef EXMEM_SKID_EN
    cyc();
    drive('0, 1'b0);
    checks++;
    if (bus.ReadyE !== 1'b0 || bus.AluResultM !== 32'hA) begin
      failures++;
      $display("FAIL stall_full got ready=%b alu=%h exp ready=0 alu=a", bus.ReadyE, bus.AluResultM);
    end
    cyc();
    checks++;
    if (bus.AluResultM !== 32'hA || bus.ValidM !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold got alu=%h v=%b exp alu=a v=1", bus.AluResultM, bus.ValidM);
    end
    bus.ReadyM = 1'b1;
    cyc();
    checks++;
    if (bus.AluResultM !== 32'hB || bus.ValidM !== 1'b1 || bus.ReadyE !== 1'b1) begin
      failures++;
      $display("FAIL stall_drain got alu=%h v=%b r=%b exp alu=b v=1 r=1",
               bus.AluResultM, bus.ValidM, bus.ReadyE);
    end
`else
    #1;
    checks++;
    if (bus.ReadyE !== 1'b0 || bus.AluResultM !== 32'hA) begin
      failures++;
      $display("FAIL stall_ready_low got ready=%b alu=%h exp ready=0 alu=a", bus.ReadyE, bus.AluResultM);
    end
    cyc();
    checks++;
    if (bus.AluResultM !== 32'hA || bus.ValidM !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold got alu=%h v=%b exp alu=a v=1", bus.AluResultM, bus.ValidM);
    end
    bus.ReadyM = 1'b1;
    #1;
    checks++;
    if (bus.ReadyE !== 1'b1) begin failures++; $display("FAIL stall_ready_comb got=%b exp=1", bus.ReadyE); end
    cyc();
    drive('0, 1'b0);
    checks++;
    if (bus.AluResultM !== 32'hB || bus.ValidM !== 1'b1) begin
      failures++;
      $display("FAIL stall_next got alu=%h v=%b exp alu=b v=1", bus.AluResultM, bus.ValidM);
    end
`endif
    drive('0, 1'b0);
    cyc();
    checks++;
    if (bus.ValidM !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", bus.ValidM); end
  endtask

  task automatic test_flush();
    pl_t p;
    bus.ReadyM = 1'b0;
    p = rand_pl(); p.mw = 1'b1;
    drive(p, 1'b1);
    cyc();
`ifdef EXMEM_SKID_EN
    p = rand_pl(); p.mw = 1'b1;
    drive(p, 1'b1);
    cyc();
`endif
    p = rand_pl(); p.mw = 1'b1;
    drive(p, 1'b1);
    bus.FlushM = 1'b1;
    cyc();
    bus.FlushM = 1'b0;
    drive('0, 1'b0);
    checks++;
    if (bus.ValidM !== 1'b0 || bus.MemWriteM !== 1'b0 || bus.ReadyE !== 1'b1) begin
      failures++;
      $display("FAIL flush got v=%b mw=%b r=%b exp v=0 mw=0 r=1", bus.ValidM, bus.MemWriteM, bus.ReadyE);
    end
    bus.ReadyM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (bus.ValidM !== 1'b0) begin failures++; $display("FAIL flush_ghost_%0d got=%b exp=0", i, bus.ValidM); end
    end
  endtask

  task automatic test_gating();
    pl_t p;
    bus.ReadyM = 1'b1;
    p = rand_pl(); p.rw = 1'b1; p.rd = 5'd7;
    drive(p, 1'b1);
    cyc();
    drive('0, 1'b0);
    checks++;
    if (bus.RegWriteM !== 1'b1 || bus.RdM !== 5'd7) begin
      failures++;
      $display("FAIL gate_on got rw=%b rd=%0d exp rw=1 rd=7", bus.RegWriteM, bus.RdM);
    end
    cyc();
    checks++;
    if (bus.RegWriteM !== 1'b0 || bus.ValidM !== 1'b0) begin
      failures++;
      $display("FAIL gate_off got rw=%b v=%b exp rw=0 v=0", bus.RegWriteM, bus.ValidM);
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    for (int i = 0; i < 300; i++) begin
      drive(rand_pl(), 1'($urandom_range(0, 3) != 0));
      bus.ReadyM = 1'($urandom_range(0, 2) != 0);
      bus.FlushM = 1'($urandom_range(0, 24) == 0);
      cyc();
    end
    bus.FlushM = 1'b0;
    drive('0, 1'b0);
    bus.ReadyM = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      cyc();
      budget++;
    end
    cyc();
    checks++;
    if (q.size() != 0 || bus.ValidM !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got pending=%0d v=%b exp pending=0 v=0", q.size(), bus.ValidM);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_gating();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
